// File: rtl/if_id_redirect_unit.sv
// IF/ID pipeline register with branch/jump resolution and wrong-path squash for the MIPS fetch stage.
// Define DELAY_SLOT_EN to keep the redirect-slot instruction instead of squashing it; JAL then links to PC+8.
module if_id_redirect_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Instruction_in,
    input  logic [31:0] PCAdder_in,
    input  logic        Stall_in,
    input  logic [31:0] RegA_in,
    input  logic [31:0] RegB_in,
    output logic [31:0] Instruction_out,
    output logic [31:0] PCPlus4_out,
    output logic        Valid_out,
    output logic        BranchResult_out,
    output logic        JumpControl_out,
    output logic [31:0] BranchTarget_out,
    output logic [31:0] JumpField_out,
    output logic [31:0] LinkAddr_out
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;

    typedef enum logic {RUN, SQUASH} state_t;

    state_t      state, state_next;
    logic [31:0] instr_q, pc4_q;
    logic        valid_q, valid_next;
    logic [5:0]  opcode, funct;
    logic [4:0]  rt;
    logic        a_eq_b, a_neg, a_zero;
    logic        branch_taken, is_jump, is_jr, live, redirect;

    assign opcode = instr_q[31:26];
    assign rt     = instr_q[20:16];
    assign funct  = instr_q[5:0];
    assign a_eq_b = (RegA_in == RegB_in);
    assign a_neg  = RegA_in[31];
    assign a_zero = (RegA_in == 32'd0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        branch_taken = 1'b0;
        is_jump      = 1'b0;
        is_jr        = 1'b0;
        case (opcode)
            OP_BEQ:     branch_taken = a_eq_b;
            OP_BNE:     branch_taken = !a_eq_b;
            OP_BLEZ:    branch_taken = a_neg || a_zero;
            OP_BGTZ:    branch_taken = !a_neg && !a_zero;
            OP_REGIMM: begin
                if (rt == 5'd0)      branch_taken = a_neg;
                else if (rt == 5'd1) branch_taken = !a_neg;
            end
            OP_J, OP_JAL: is_jump = 1'b1;
            OP_SPECIAL:   is_jr   = (funct == FN_JR);
            default: ;
        endcase
    end

    // A stalled transfer is resolved later, on its first non-stalled cycle.
    assign live             = valid_q && !Stall_in;
    assign BranchResult_out = live && (branch_taken || is_jr);
    assign JumpControl_out  = live && is_jump;
    assign redirect         = BranchResult_out || JumpControl_out;

    assign BranchTarget_out = is_jr ? RegA_in
                                    : pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign JumpField_out    = {4'b0000, instr_q[25:0], 2'b00};

    always_comb begin
        state_next = state;
        valid_next = valid_q;
        if (!Stall_in) begin
            case (state)
                RUN: begin
                    if (redirect) begin
`ifdef DELAY_SLOT_EN
                        state_next = RUN;
                        valid_next = 1'b1;
`else
                        state_next = SQUASH;
                        valid_next = 1'b0;
`endif
                    end else begin
                        valid_next = 1'b1;
                    end
                end
                SQUASH: begin
                    state_next = RUN;
                    valid_next = 1'b1;
                end
                default: begin
                    state_next = RUN;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= RUN;
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            valid_q <= valid_next;
            if (!Stall_in) begin
                instr_q <= Instruction_in;
                pc4_q   <= PCAdder_in;
            end
        end
    end

`ifdef DELAY_SLOT_EN
    // Registered so the link value is zero in reset like every other output.
    logic [31:0] link_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)           link_q <= 32'd0;
        else if (!Stall_in) link_q <= PCAdder_in + 32'd4;
    end

    assign LinkAddr_out = link_q;
`else
    assign LinkAddr_out = pc4_q;
`endif

    assign Instruction_out = instr_q;
    assign PCPlus4_out     = pc4_q;
    assign Valid_out       = valid_q;

endmodule

// File: tb/tb_if_id_redirect_unit.sv
// Self-checking bench for if_id_redirect_unit: directed cases then randomized traffic against a slot-level model.
// Honors DELAY_SLOT_EN the same way the design does.
module tb_if_id_redirect_unit;

`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    localparam logic [31:0] I_ADDI = 32'h2008_0005;
    localparam logic [31:0] I_BEQ3 = 32'h1000_0003;
    localparam logic [31:0] I_BNE  = 32'h1400_FFFF;
    localparam logic [31:0] I_J40  = 32'h0800_0040;
    localparam logic [31:0] I_JR   = 32'h0000_0008;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_NOP  = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] drv_instr, drv_pc4, drv_a, drv_b;
    logic        drv_stall;
    logic [31:0] Instruction_out, PCPlus4_out, BranchTarget_out, JumpField_out, LinkAddr_out;
    logic        Valid_out, BranchResult_out, JumpControl_out;

    if_id_redirect_unit dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .Instruction_in   (drv_instr),
        .PCAdder_in       (drv_pc4),
        .Stall_in         (drv_stall),
        .RegA_in          (drv_a),
        .RegB_in          (drv_b),
        .Instruction_out  (Instruction_out),
        .PCPlus4_out      (PCPlus4_out),
        .Valid_out        (Valid_out),
        .BranchResult_out (BranchResult_out),
        .JumpControl_out  (JumpControl_out),
        .BranchTarget_out (BranchTarget_out),
        .JumpField_out    (JumpField_out),
        .LinkAddr_out     (LinkAddr_out)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Model of the slot currently held in IF/ID.
    logic [31:0] m_instr, m_pc4, m_link;
    logic        m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Returns {branch_result, jump_control} for the modelled slot and current register operands.
    function automatic logic [1:0] model_ctrl();
        int          op, rt, fn, sa;
        logic        br, jc;
        op = int'(m_instr[31:26]);
        rt = int'(m_instr[20:16]);
        fn = int'(m_instr[5:0]);
        sa = int'(drv_a);
        br = 1'b0;
        jc = 1'b0;
        if (m_valid && !drv_stall) begin
            if (op == 4 && drv_a == drv_b)           br = 1'b1;
            if (op == 5 && drv_a != drv_b)           br = 1'b1;
            if (op == 6 && sa <= 0)                  br = 1'b1;
            if (op == 7 && sa > 0)                   br = 1'b1;
            if (op == 1 && rt == 0 && sa < 0)        br = 1'b1;
            if (op == 1 && rt == 1 && sa >= 0)       br = 1'b1;
            if (op == 0 && fn == 8)                  br = 1'b1;
            if (op == 2 || op == 3)                  jc = 1'b1;
        end
        return {br, jc};
    endfunction

    function automatic logic [31:0] model_target();
        int          imm;
        if (m_instr[31:26] == 6'd0 && m_instr[5:0] == 6'd8) return drv_a;
        imm = int'($signed(m_instr[15:0]));
        return m_pc4 + 32'(imm * 4);
    endfunction

    task automatic model_reset();
        m_instr = 32'd0;
        m_pc4   = 32'd0;
        m_link  = 32'd0;
        m_valid = 1'b0;
    endtask

    task automatic check_outputs();
        logic [1:0] ctrl;
        ctrl = model_ctrl();
        check("instr",  Instruction_out, m_instr);
        check("pc4",    PCPlus4_out, m_pc4);
        check("valid",  32'(Valid_out), 32'(m_valid));
        check("br",     32'(BranchResult_out), 32'(ctrl[1]));
        check("jc",     32'(JumpControl_out), 32'(ctrl[0]));
        check("target", BranchTarget_out, model_target());
        check("jfield", JumpField_out, (m_instr & 32'h03FF_FFFF) << 2);
        check("link",   LinkAddr_out, m_link);
    endtask

    // Called at the falling edge: drive the cycle's inputs, then compare settled outputs.
    task automatic apply(input logic [31:0] instr, input logic [31:0] pc4,
                         input logic [31:0] a, input logic [31:0] b, input logic stall);
        drv_instr = instr;
        drv_pc4   = pc4;
        drv_a     = a;
        drv_b     = b;
        drv_stall = stall;
        #1;
        check_outputs();
    endtask

    // A slot following a taken transfer is dead unless delay slots are kept.
    task automatic tick();
        logic [1:0] ctrl;
        ctrl = model_ctrl();
        @(posedge Clk);
        if (!drv_stall) begin
            m_valid = DS ? 1'b1 : (ctrl == 2'b00);
            m_instr = drv_instr;
            m_pc4   = drv_pc4;
            m_link  = DS ? drv_pc4 + 32'd4 : drv_pc4;
        end
        @(negedge Clk);
    endtask

    // Asserts reset between clock edges and holds it across one rising edge.
    task automatic async_reset();
        #1 Rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("rst_valid", 32'(Valid_out), 32'd0);
        check("rst_br",    32'(BranchResult_out), 32'd0);
        check("rst_tgt",   BranchTarget_out, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[31:26] = 6'd4;
            1: r[31:26] = 6'd5;
            2: r[31:26] = 6'd6;
            3: r[31:26] = 6'd7;
            4: begin r[31:26] = 6'd1; r[20:16] = 5'($urandom_range(0, 2)); end
            5: r[31:26] = 6'd2;
            6: r[31:26] = 6'd3;
            7: begin r[31:26] = 6'd0; r[5:0] = 6'd8; end
            8: r[31:26] = 6'd0;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'd7;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        Rst = 1'b0;
        drv_instr = '0; drv_pc4 = '0; drv_a = '0; drv_b = '0; drv_stall = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge Clk);
        Rst = 1'b1;

        apply(I_ADDI, 32'h4, 0, 0, 1'b0); tick();
        apply(I_BEQ3, 32'h10, 0, 0, 1'b0);
        check("addi_instr", Instruction_out, 32'h2008_0005);
        check("addi_pc4",   PCPlus4_out, 32'h4);
        check("addi_valid", 32'(Valid_out), 32'd1);
        check("addi_br",    32'(BranchResult_out), 32'd0);
        tick();
        apply(I_NOP, 32'h14, 32'd7, 32'd7, 1'b0);
        check("beq_br",  32'(BranchResult_out), 32'd1);
        check("beq_tgt", BranchTarget_out, 32'h1C);
        tick();
        apply(I_NOP, 32'h1C, 0, 0, 1'b0);
        check("beq_slot_valid", 32'(Valid_out), 32'(DS));
        tick();
        apply(I_BEQ3, 32'h10, 0, 0, 1'b0);
        check("beq_recover_valid", 32'(Valid_out), 32'd1);
        tick();
        apply(I_NOP, 32'h14, 32'd7, 32'd8, 1'b0);
        check("beq_nt_br", 32'(BranchResult_out), 32'd0);
        tick();
        apply(I_BNE, 32'h20, 0, 0, 1'b0);
        check("beq_nt_valid", 32'(Valid_out), 32'd1);
        tick();
        apply(I_NOP, 32'h24, 32'd1, 32'd2, 1'b0);
        check("bne_br",  32'(BranchResult_out), 32'd1);
        check("bne_tgt", BranchTarget_out, 32'h1C);
        tick();
        apply(I_J40, 32'h1C, 0, 0, 1'b0); tick();
        apply(I_NOP, 32'h20, 0, 0, 1'b0);
        check("j_jc",    32'(JumpControl_out), 32'd1);
        check("j_br",    32'(BranchResult_out), 32'd0);
        check("j_field", JumpField_out, 32'h100);
        tick();
        apply(I_JR, 32'h104, 0, 0, 1'b0); tick();
        apply(I_NOP, 32'h108, 32'h400, 0, 1'b0);
        check("jr_br",  32'(BranchResult_out), 32'd1);
        check("jr_tgt", BranchTarget_out, 32'h400);
        check("jr_jc",  32'(JumpControl_out), 32'd0);
        tick();
        apply(I_BEQ3, 32'h10, 0, 0, 1'b0); tick();
        apply(I_NOP, 32'h14, 32'd7, 32'd7, 1'b1);
        check("stall_br1", 32'(BranchResult_out), 32'd0);
        tick();
        apply(I_NOP, 32'h14, 32'd7, 32'd7, 1'b1);
        check("stall_hold", Instruction_out, I_BEQ3);
        check("stall_br2",  32'(BranchResult_out), 32'd0);
        tick();
        apply(I_NOP, 32'h14, 32'd7, 32'd7, 1'b0);
        check("unstall_br", 32'(BranchResult_out), 32'd1);
        tick();
        apply(I_NOP, 32'h1C, 0, 0, 1'b0);
        check("squash_valid", 32'(Valid_out), 32'(DS));
        async_reset();
        apply(I_JAL, 32'h30, 0, 0, 1'b0); tick();
        apply(I_NOP, 32'h34, 0, 0, 1'b0);
        check("jal_jc",   32'(JumpControl_out), 32'd1);
        check("jal_link", LinkAddr_out, DS ? 32'h34 : 32'h30);
        tick();
        apply(I_NOP, 32'h38, 0, 0, 1'b0);
        check("jal_slot_valid", 32'(Valid_out), 32'(DS));
        tick();

        for (int i = 0; i < 600; i++) begin
            a = rand_operand();
            apply(rand_instr(), $urandom & 32'hFFFF_FFFC, a,
                  ($urandom_range(0, 1) == 0) ? a : rand_operand(),
                  $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0) async_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_redirect_unit.md
# if_id_redirect_unit

IF/ID pipeline register plus control-transfer resolver for the MIPS datapath. Captures the instruction and PC+4 produced by the fetch stage. Decodes branches and jumps held in IF/ID and drives the fetch stage's redirect controls (PCSrc select, jump select, branch/JR target, shifted jump field). Squashes the wrong-path instruction fetched during a taken redirect.

## Interface
Parameters:
- none (widths fixed at 32-bit MIPS).

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-low reset
- Instruction_in  input  32  instruction from fetch stage
- PCAdder_in  input  32  PC+4 from fetch stage
- Stall_in  input  1  hazard stall; holds IF/ID and suppresses redirect
- RegA_in  input  32  rs read data for the IF/ID instruction
- RegB_in  input  32  rt read data for the IF/ID instruction
- Instruction_out  output  32  registered instruction
- PCPlus4_out  output  32  registered PC+4
- Valid_out  output  1  IF/ID entry is architecturally live
- BranchResult_out  output  1  selects BranchTarget_out in fetch PCSrc mux
- JumpControl_out  output  1  selects jump address in fetch jump mux
- BranchTarget_out  output  32  branch target, or RegA_in for JR
- JumpField_out  output  32  {4'b0, instr[25:0], 2'b00}; fetch merges PC[31:28]
- LinkAddr_out  output  32  JAL link value

## Operation
- IF/ID register (Instruction_out, PCPlus4_out, Valid_out) updates every edge unless Stall_in=1, in which case it holds.
- FSM states: RUN, SQUASH.
  - RUN: if Valid_out=1, Stall_in=0 and the IF/ID instruction is a taken transfer, assert the redirect outputs combinationally this cycle. At the edge, load IF/ID from fetch with Valid_out=0 and go to SQUASH.
  - SQUASH: no redirect is possible (Valid_out=0). At the next non-stalled edge, load normally with Valid_out=1 and go to RUN.
- Decode applies to the IF/ID instruction only, and only when Valid_out=1:
  - beq (000100): taken if RegA==RegB.
  - bne (000101): taken if RegA!=RegB.
  - blez (000110): taken if signed RegA<=0.
  - bgtz (000111): taken if signed RegA>0.
  - opcode 000001, rt=00000 bltz: taken if RegA<0.
  - opcode 000001, rt=00001 bgez: taken if RegA>=0.
  - j (000010) and jal (000011): JumpControl_out=1.
  - jr (opcode 0, funct 001000): BranchResult_out=1, BranchTarget_out=RegA_in.
- Branch target = PCPlus4_out + (sign-extended imm16 << 2), modulo 2^32 (wrap-around allowed).
- JumpField_out and BranchTarget_out are always driven. Only the control bits qualify them.
- At most one of BranchResult_out and JumpControl_out is high.
- Not-taken branches cause no redirect and no squash.
- LinkAddr_out = PCPlus4_out (no delay slot) or PCPlus4_out+4 (see Configuration).

## Timing
- Reset: Instruction_out, PCPlus4_out, LinkAddr_out, BranchTarget_out, JumpField_out = 0; Valid_out=0; redirect bits=0; state RUN.
- First fetched instruction after reset release is Valid_out=1.
- Redirect latency: the transfer instruction enters IF/ID at edge N. The redirect is asserted during cycle N. Fetch PC = target after edge N+1. The target instruction is in IF/ID after edge N+2.
- Exactly one wrong-path slot is squashed per taken transfer.
- Stall_in=1 in SQUASH: remain in SQUASH, hold, Valid_out stays 0.
- Stall_in=1 with a taken transfer in IF/ID: no redirect. It resolves on the first non-stalled cycle.
- Reset asserted mid-SQUASH: immediate return to reset values. No pending redirect survives.

## Configuration
- DELAY_SLOT_EN defined:
  - The instruction fetched during a redirect is kept (Valid_out=1, state stays RUN).
  - LinkAddr_out = PCPlus4_out+4.
- DELAY_SLOT_EN undefined:
  - The squash behaviour above applies.
  - LinkAddr_out = PCPlus4_out.

## Test plan
- Reset, then feed instruction 0x20080005 at PC+4=0x4 → after one edge: Instruction_out=0x20080005, PCPlus4_out=0x4, Valid_out=1, no redirect.
- beq imm=0x0003 with PCPlus4=0x10 and RegA=RegB=7 → BranchResult_out=1, BranchTarget_out=0x1C. Next edge: Valid_out=0. Following edge: Valid_out=1.
- Same beq with RegA=7, RegB=8 → no redirect, no squash.
- bne imm=0xFFFF with PCPlus4=0x20 and RegA≠RegB → BranchTarget_out=0x1C.
- j 0x0000040 → JumpControl_out=1, JumpField_out=0x100.
- jr with RegA=0x400 → BranchResult_out=1, BranchTarget_out=0x400.
- beq taken while Stall_in=1 for 2 cycles → no redirect and IF/ID held. Redirect asserts in the cycle Stall_in falls.
- Rst low during SQUASH → all outputs 0 asynchronously.
- With DELAY_SLOT_EN: jal → slot instruction keeps Valid_out=1, LinkAddr_out=PCPlus4+4.
